// File: rtl/reg_universal_pkg.sv
// rtl/reg_universal_pkg.sv - shared types for the universal shift register
package reg_universal_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 3'd0,
      MODE_LOAD = 3'd1,
      MODE_SHL  = 3'd2,
      MODE_SHR  = 3'd3,
      MODE_ROTL = 3'd4,
      MODE_ROTR = 3'd5
   } mode_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/reg_universal_next.sv
// rtl/reg_universal_next.sv - combinational next-value select for the register
module reg_universal_next
   import reg_universal_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]  q,
   input  logic [WIDTH-1:0]  d,
   input  logic              ser_in,
   input  logic [MODE_W-1:0] mode,
   output logic [WIDTH-1:0]  q_next
);

   // Unused codes 6 and 7 fall through to hold.
   always_comb begin
      q_next = q;
      case (mode)
         MODE_LOAD: q_next = d;
         MODE_SHL:  q_next = {q[WIDTH-2:0], ser_in};
         MODE_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
         MODE_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROTR: q_next = {q[0], q[WIDTH-1:1]};
         default:   q_next = q;
      endcase
   end

endmodule

// File: rtl/reg_universal.sv
// rtl/reg_universal.sv - universal register with a WIDTH-cycle auto-shift sequence
module reg_universal
   import reg_universal_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              ser_in,
   input  logic              start,
   output logic [WIDTH-1:0]  q,
   output logic              ser_out,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nx;
   logic              done_nx;
   logic [WIDTH-1:0]  q_sel;
   logic [WIDTH-1:0]  q_nx;
   logic [MODE_W-1:0] mode_eff;

   // A running sequence forces SHR, so the same select block serves both paths.
   assign mode_eff = (state == ST_SHIFT) ? MODE_SHR : mode;

   reg_universal_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .q      (q),
      .d      (d),
      .ser_in (ser_in),
      .mode   (mode_eff),
      .q_next (q_sel)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         q     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         q     <= q_nx;
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      done_nx  = 1'b0;
      q_nx     = q;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx = ST_SHIFT;
               cnt_nx   = CW'(WIDTH);
            end else begin
               q_nx = q_sel;
            end
         end
         ST_SHIFT: begin
            q_nx = q_sel;
            if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end
            // Last shift: leave on this edge and flag completion for one cycle.
            if (cnt <= CW'(1)) begin
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy    = (state == ST_SHIFT);
      ser_out = q[0];
   end

endmodule

// File: tb/tb_reg_universal.sv
// tb/tb_reg_universal.sv - randomized self-checking bench for reg_universal
module tb_reg_universal;

   logic       clk;
   logic       reset;
   logic [2:0] mode;
   logic [7:0] d;
   logic       ser_in;
   logic       start;
   logic [7:0] q;
   logic       ser_out;
   logic       busy;
   logic       done;

   int checks;
   int failures;
   logic [7:0] mq;

   reg_universal #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .mode    (mode),
      .d       (d),
      .ser_in  (ser_in),
      .start   (start),
      .q       (q),
      .ser_out (ser_out),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model_op(input logic [7:0] cur, input logic [7:0] din,
                                           input logic si, input int m);
      int v;
      v = int'(cur);
      case (m)
         1: v = int'(din);
         2: v = ((v * 2) + int'(si)) % 256;
         3: v = (v / 2) + int'(si) * 128;
         4: v = ((v * 2) % 256) + (v / 128);
         5: v = (v / 2) + (v % 2) * 128;
         default: v = v;
      endcase
      return 8'(v);
   endfunction

   task automatic test_reset();
      reset = 1'b1; d = 8'hFF; mode = 3'd1; start = 1'b1; ser_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
         checks++; if (ser_out !== 1'b0) begin failures++; $display("FAIL reset_ser_out got=%b exp=0", ser_out); end
      end
      reset = 1'b0; start = 1'b0; mode = 3'd0;
      mq = 8'h00;
   endtask

   task automatic test_modes_directed();
      logic [7:0] exp_tab [5];
      exp_tab[0] = 8'hA5; exp_tab[1] = 8'h4B; exp_tab[2] = 8'hA5;
      exp_tab[3] = 8'h4B; exp_tab[4] = 8'hA5;
      d = 8'hA5; ser_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mode = 3'(i + 1);
         step();
         mq = model_op(mq, d, ser_in, i + 1);
         checks++; if (q !== exp_tab[i]) begin failures++; $display("FAIL mode_%0d got=%h exp=%h", i + 1, q, exp_tab[i]); end
      end
      mode = 3'd6; d = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (q !== 8'hA5) begin failures++; $display("FAIL mode6_hold got=%h exp=a5", q); end
      end
      mode = 3'd0;
   endtask

   task automatic test_random_modes();
      int m;
      for (int i = 0; i < 200; i++) begin
         m = $urandom_range(0, 7);
         mode = 3'(m); d = 8'($urandom); ser_in = 1'($urandom); start = 1'b0;
         step();
         mq = model_op(mq, d, ser_in, m);
         checks++; if (q !== mq) begin failures++; $display("FAIL rand_mode_%0d q got=%h exp=%h", m, q, mq); end
         checks++; if (ser_out !== mq[0]) begin failures++; $display("FAIL rand_ser_out got=%b exp=%b", ser_out, mq[0]); end
         checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rand_idle busy=%b done=%b exp=0/0", busy, done); end
      end
      mode = 3'd0;
   endtask

   task automatic launch(input logic [7:0] si_val);
      start = 1'b1; mode = 3'($urandom_range(1, 5)); ser_in = si_val[0]; d = 8'($urandom);
      step();
      start = 1'b0;
   endtask

   // Expects the start edge to have just been taken; leaves the bench in the done cycle
   // with start driven to chain_next before stepping out of it.
   task automatic run_seq(input bit hold_start, input bit fixed_zero, input bit chain_next);
      logic [7:0] orig;
      logic       si;
      orig = mq;
      checks++; if (q !== orig) begin failures++; $display("FAIL seq_start_q got=%h exp=%h", q, orig); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL seq_busy_%0d got=%b exp=1", i, busy); end
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL seq_done_early_%0d got=%b exp=0", i, done); end
         checks++; if (ser_out !== orig[i]) begin failures++; $display("FAIL seq_ser_out_%0d got=%b exp=%b", i, ser_out, orig[i]); end
         si = fixed_zero ? 1'b0 : 1'($urandom);
         ser_in = si; mode = 3'($urandom); d = 8'($urandom);
         start = hold_start ? 1'b1 : 1'($urandom_range(0, 3) == 0);
         step();
         mq = (mq >> 1) | (8'(si) << 7);
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seq_busy_end got=%b exp=0", busy); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL seq_done got=%b exp=1", done); end
      checks++; if (q !== mq) begin failures++; $display("FAIL seq_final_q got=%h exp=%h", q, mq); end
      start = chain_next; mode = 3'd0;
      step();
      if (chain_next) begin
         start = 1'b0;
      end else begin
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL seq_after done=%b busy=%b exp=0/0", done, busy); end
      end
   endtask

   task automatic test_auto_shift();
      mode = 3'd1; d = 8'hB4; step(); mq = 8'hB4; mode = 3'd0;
      start = 1'b1; ser_in = 1'b0; step(); start = 1'b0;
      run_seq(1'b0, 1'b1, 1'b0);
      checks++; if (q !== 8'h00) begin failures++; $display("FAIL b4_final got=%h exp=00", q); end
   endtask

   task automatic test_start_held();
      mode = 3'd1; d = 8'($urandom); step(); mq = d; mode = 3'd0;
      launch(8'($urandom));
      run_seq(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_abort();
      mode = 3'd1; d = 8'h5A; step(); mq = 8'h5A; mode = 3'd0;
      launch(8'h00);
      for (int i = 0; i < 3; i++) begin
         ser_in = 1'($urandom); step();
      end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy4 got=%b exp=1", busy); end
      reset = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; start = 1'b0; mq = 8'h00;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (q !== 8'h00) begin failures++; $display("FAIL abort_q got=%h exp=00", q); end
      for (int i = 0; i < 12; i++) begin
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done_%0d got=%b exp=0", i, done); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      mode = 3'd1; d = 8'h0F; step(); mq = 8'h0F; mode = 3'd0;
      launch(8'($urandom));
      run_seq(1'b0, 1'b0, 1'b1);
      run_seq(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random_sequences();
      for (int k = 0; k < 6; k++) begin
         mode = 3'd1; d = 8'($urandom); start = 1'b0; step(); mq = d; mode = 3'd0;
         launch(8'($urandom));
         run_seq(1'($urandom), 1'b0, 1'b0);
      end
   endtask

   initial begin
      checks = 0; failures = 0; mq = 8'h00;
      reset = 1'b1; mode = 3'd0; d = 8'h00; ser_in = 1'b0; start = 1'b0;
      test_reset();
      test_modes_directed();
      test_random_modes();
      test_auto_shift();
      test_start_held();
      test_reset_abort();
      test_back_to_back();
      test_random_sequences();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
